// File: rtl/serv_rf_ram_arb.sv
// Register-file RAM sequencer/arbiter: optional post-reset zero fill, core
// pass-through, and a 32-bit debug port serialised into RAM-width beats.
module serv_rf_ram_arb #(
    parameter int unsigned width    = 2,
    parameter int unsigned csr_regs = 4,
    parameter int unsigned CLEAR    = 1,
    parameter int unsigned DEPTH    = (32 + csr_regs) * 32 / width,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_rst,
    // core side
    input  logic [AW-1:0]    i_c_waddr,
    input  logic [width-1:0] i_c_wdata,
    input  logic             i_c_wen,
    input  logic [AW-1:0]    i_c_raddr,
    output logic [width-1:0] o_c_rdata,
    // RAM side
    output logic [AW-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [AW-1:0]    o_raddr,
    input  logic [width-1:0] i_rdata,
    // core handshake
    input  logic             i_core_idle,
    output logic             o_core_stall,
    output logic             o_clr_done,
    // debug port
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [5:0]       i_dbg_reg,
    input  logic [31:0]      i_dbg_wdat,
    output logic [31:0]      o_dbg_rdat,
    output logic             o_dbg_ack
);

    localparam int unsigned N     = 32 / width;
    localparam int unsigned BCW   = $clog2(N + 1);
    localparam int unsigned NREGS = 32 + csr_regs;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_DRD,
        S_DWR
    } state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [BCW-1:0]   beat;
    logic [5:0]       reg_q;
    logic [31:0]      wdat_q;

    logic             reg_ok;
    logic             grant;
    logic [AW-1:0]    dbg_addr;
    logic [31+width:0] rd_cat;

    // Register 0 and indices past the CSR slots never write and read as zero
    assign reg_ok   = (reg_q != 6'd0) && (32'(reg_q) < NREGS);
    assign grant    = i_dbg_req && i_core_idle && !o_dbg_ack;
    assign dbg_addr = AW'(32'(reg_q) * N + 32'(beat));
    // Returned beat enters at the top so beat 0 ends up in the LSBs
    assign rd_cat   = {(reg_ok ? i_rdata : {width{1'b0}}), o_dbg_rdat};

    assign o_c_rdata = i_rdata;

    // Sequencer state, beat/clear counters and registered handshake outputs
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= (CLEAR != 0) ? S_CLEAR : S_IDLE;
            cnt          <= '0;
            beat         <= '0;
            reg_q        <= '0;
            wdat_q       <= '0;
            o_dbg_ack    <= 1'b0;
            o_dbg_rdat   <= '0;
            o_clr_done   <= 1'b0;
            o_core_stall <= (CLEAR != 0);
        end else begin
            o_dbg_ack <= 1'b0;
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(DEPTH - 1)) begin
                        state        <= S_IDLE;
                        o_clr_done   <= 1'b1;
                        o_core_stall <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (grant) begin
                        reg_q        <= i_dbg_reg;
                        wdat_q       <= i_dbg_wdat;
                        beat         <= '0;
                        o_core_stall <= 1'b1;
                        state        <= i_dbg_we ? S_DWR : S_DRD;
                    end
                end
                S_DRD: begin
                    beat <= beat + BCW'(1);
                    // RAM data lags the address by one cycle; nothing valid yet at beat 0
                    if (beat != '0) begin
                        o_dbg_rdat <= rd_cat[31+width:width];
                    end
                    if (beat == BCW'(N)) begin
                        state        <= S_IDLE;
                        o_dbg_ack    <= 1'b1;
                        o_core_stall <= 1'b0;
                    end
                end
                S_DWR: begin
                    beat   <= beat + BCW'(1);
                    wdat_q <= wdat_q >> width;
                    if (beat == BCW'(N - 1)) begin
                        state        <= S_IDLE;
                        o_dbg_ack    <= 1'b1;
                        o_core_stall <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM port steering: core pass-through unless the sequencer owns the RAM
    always_comb begin
        o_waddr = i_c_waddr;
        o_wdata = i_c_wdata;
        o_wen   = i_c_wen;
        o_raddr = i_c_raddr;
        case (state)
            S_CLEAR: begin
                o_waddr = cnt;
                o_wdata = '0;
                o_wen   = 1'b1;
            end
            S_DRD: begin
                o_wen   = 1'b0;
                o_raddr = dbg_addr;
            end
            S_DWR: begin
                o_wen   = reg_ok;
                o_waddr = dbg_addr;
                o_wdata = wdat_q[width-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// Directed bench for serv_rf_ram_arb with a registered-read RAM model.
module tb_serv_rf_ram_arb;

    localparam int unsigned W     = 2;
    localparam int unsigned CSR   = 4;
    localparam int unsigned DEPTH = (32 + CSR) * 32 / W;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned N     = 32 / W;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [AW-1:0] i_c_waddr;
    logic [W-1:0]  i_c_wdata;
    logic          i_c_wen;
    logic [AW-1:0] i_c_raddr;
    logic [W-1:0]  o_c_rdata;
    logic [AW-1:0] o_waddr;
    logic [W-1:0]  o_wdata;
    logic          o_wen;
    logic [AW-1:0] o_raddr;
    logic [W-1:0]  i_rdata;
    logic          i_core_idle;
    logic          o_core_stall;
    logic          o_clr_done;
    logic          i_dbg_req;
    logic          i_dbg_we;
    logic [5:0]    i_dbg_reg;
    logic [31:0]   i_dbg_wdat;
    logic [31:0]   o_dbg_rdat;
    logic          o_dbg_ack;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [W-1:0] mem [0:DEPTH-1];
    logic         prefill = 1'b0;
    int unsigned  wen_seen = 0;
    int unsigned  ack_seen = 0;

    always #5 clk = ~clk;

    serv_rf_ram_arb #(.width(W), .csr_regs(CSR), .CLEAR(1)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_c_waddr(i_c_waddr), .i_c_wdata(i_c_wdata), .i_c_wen(i_c_wen),
        .i_c_raddr(i_c_raddr), .o_c_rdata(o_c_rdata),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
        .o_raddr(o_raddr), .i_rdata(i_rdata),
        .i_core_idle(i_core_idle), .o_core_stall(o_core_stall),
        .o_clr_done(o_clr_done),
        .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_reg(i_dbg_reg),
        .i_dbg_wdat(i_dbg_wdat), .o_dbg_rdat(o_dbg_rdat), .o_dbg_ack(o_dbg_ack)
    );

    // RAM with 1-cycle registered read; out-of-range reads return all ones
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '1;
        end else if (o_wen && (32'(o_waddr) < DEPTH)) begin
            mem[o_waddr] <= o_wdata;
        end
        i_rdata <= (32'(o_raddr) < DEPTH) ? mem[o_raddr] : '1;
        if (o_wen)     wen_seen <= wen_seen + 1;
        if (o_dbg_ack) ack_seen <= ack_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a debug access and return the number of edges from grant to ack
    task automatic dbg_op(input logic we, input logic [5:0] rg, input logic [31:0] wd,
                          output int lat);
        i_dbg_req   = 1'b1;
        i_dbg_we    = we;
        i_dbg_reg   = rg;
        i_dbg_wdat  = wd;
        i_core_idle = 1'b1;
        tick();
        chk("stall_after_grant", 32'(o_core_stall), 32'd1);
        lat = 0;
        while (!o_dbg_ack && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // Keep req high through the ack cycle, then confirm no re-grant
    task automatic end_op();
        tick();
        chk("ack_single_cycle", 32'(o_dbg_ack), 32'd0);
        chk("no_regrant_stall", 32'(o_core_stall), 32'd0);
        i_dbg_req   = 1'b0;
        i_core_idle = 1'b0;
    endtask

    task automatic wait_clear(output int n, output logic stall_bad);
        n = 0;
        stall_bad = 1'b0;
        while (!o_clr_done && n < 2000) begin
            tick();
            n++;
            if (!o_clr_done && !o_core_stall) stall_bad = 1'b1;
        end
    endtask

    initial begin
        int          lat;
        int          n;
        int          nz;
        logic        bad;
        logic [31:0] word;
        int unsigned base;

        i_rst = 1'b1;
        i_c_waddr = '0; i_c_wdata = '0; i_c_wen = 1'b0; i_c_raddr = '0;
        i_core_idle = 1'b0; i_dbg_req = 1'b0; i_dbg_we = 1'b0;
        i_dbg_reg = '0; i_dbg_wdat = '0;
        prefill = 1'b1;
        tick(); tick();
        prefill = 1'b0;
        tick();

        // reset state
        chk("rst_ack", 32'(o_dbg_ack), 32'd0);
        chk("rst_rdat", o_dbg_rdat, 32'd0);
        chk("rst_clr_done", 32'(o_clr_done), 32'd0);
        chk("rst_stall", 32'(o_core_stall), 32'd1);
        chk("rst_wen", 32'(o_wen), 32'd1);
        chk("rst_waddr", 32'(o_waddr), 32'd0);
        chk("rst_wdata", 32'(o_wdata), 32'd0);

        // zero fill
        i_rst = 1'b0;
        wait_clear(n, bad);
        chk("clear_len", 32'(n), 32'd576);
        chk("clear_stall_held", 32'(bad), 32'd0);
        chk("clear_stall_drop", 32'(o_core_stall), 32'd0);
        nz = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== '0) nz++;
        chk("clear_all_zero", 32'(nz), 32'd0);

        // core pass-through
        i_c_waddr = AW'(37); i_c_wdata = 2'b10; i_c_wen = 1'b1;
        #1;
        chk("pt_wen", 32'(o_wen), 32'd1);
        chk("pt_waddr", 32'(o_waddr), 32'd37);
        chk("pt_wdata", 32'(o_wdata), 32'd2);
        tick();
        i_c_wen = 1'b0; i_c_raddr = AW'(37);
        #1;
        chk("pt_raddr", 32'(o_raddr), 32'd37);
        tick();
        chk("pt_rdata", 32'(o_c_rdata), 32'd2);

        // debug write reg 5
        base = wen_seen;
        dbg_op(1'b1, 6'd5, 32'hDEADBEEF, lat);
        chk("wr5_latency", 32'(lat), 32'd16);
        chk("wr5_wen_count", wen_seen - base, 32'd16);
        end_op();
        word = '0;
        for (int i = 0; i < int'(N); i++) word[i*W +: W] = mem[80 + i];
        chk("wr5_ram_word", word, 32'hDEADBEEF);

        // debug read reg 5
        dbg_op(1'b0, 6'd5, 32'h0, lat);
        chk("rd5_latency", 32'(lat), 32'd17);
        chk("rd5_data", o_dbg_rdat, 32'hDEADBEEF);
        end_op();
        chk("rd5_data_hold", o_dbg_rdat, 32'hDEADBEEF);

        // debug write reg 0 is suppressed
        base = wen_seen;
        dbg_op(1'b1, 6'd0, 32'hFFFFFFFF, lat);
        chk("wr0_latency", 32'(lat), 32'd16);
        chk("wr0_no_wen", wen_seen - base, 32'd0);
        end_op();

        // put non-zero data where reg 0 lives, then read it
        i_c_waddr = AW'(3); i_c_wdata = 2'b11; i_c_wen = 1'b1;
        tick();
        i_c_wen = 1'b0;
        dbg_op(1'b0, 6'd0, 32'h0, lat);
        chk("rd0_latency", 32'(lat), 32'd17);
        chk("rd0_data", o_dbg_rdat, 32'd0);
        end_op();

        // reg 5 then out-of-range reg 40
        dbg_op(1'b0, 6'd5, 32'h0, lat);
        chk("rd5b_data", o_dbg_rdat, 32'hDEADBEEF);
        end_op();
        dbg_op(1'b0, 6'd40, 32'h0, lat);
        chk("rd40_latency", 32'(lat), 32'd17);
        chk("rd40_data", o_dbg_rdat, 32'd0);
        end_op();

        // request held while core busy: no grant
        base = ack_seen;
        i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_reg = 6'd7;
        i_dbg_wdat = 32'h12345678; i_core_idle = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (o_core_stall || o_dbg_ack) bad = 1'b1;
        end
        chk("busy_no_grant", 32'(bad), 32'd0);
        i_core_idle = 1'b1;
        tick();
        chk("idle_grant", 32'(o_core_stall), 32'd1);
        for (int i = 0; i < 7; i++) tick();
        chk("beat7_waddr", 32'(o_waddr), 32'd119);
        chk("beat7_wen", 32'(o_wen), 32'd1);

        // reset mid-write
        i_rst = 1'b1;
        #1;
        chk("midrst_stall", 32'(o_core_stall), 32'd1);
        chk("midrst_waddr", 32'(o_waddr), 32'd0);
        chk("midrst_clr_done", 32'(o_clr_done), 32'd0);
        i_dbg_req = 1'b0; i_core_idle = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
        wait_clear(n, bad);
        chk("reclear_len", 32'(n), 32'd576);
        chk("reclear_stall_held", 32'(bad), 32'd0);
        chk("midrst_no_ack", ack_seen - base, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
